norm_seq: RTL and testbench
===========================

# norm_seq

Sequencer for the per-column normalization array. It streams `col*pr` partial sums from the upstream psum source into the `col` norm lanes, `pr` values per lane in lane order. It then drains the normalized results lane by lane to the downstream consumer over a valid/ready handshake. It sits between the output FIFO / psum path and the norm lane instances, and generates every per-lane `wr`/`div` strobe.

## Interface
- `col`, 8, number of norm lanes (≥2)
- `pr`, 8, values per lane per pass (≥2)
- `psum_bw`, 12, partial-sum width
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low (0 = reset)
- `start` input 1 — begin a pass; sampled only in IDLE
- `clear` input 1 — synchronous abort to IDLE; priority over all other inputs
- `in_valid` input 1 — upstream psum valid
- `in_data` input psum_bw — upstream psum
- `in_ready` output 1 — sequencer accepts `in_data`
- `norm_in` output psum_bw — broadcast lane data, equals `in_data`
- `norm_wr` output col — one-hot lane write strobe
- `norm_div` output col — one-hot lane read/divide strobe
- `norm_ready` input col — lane result available
- `out_valid` output 1 — current lane result available downstream
- `out_ready` input 1 — downstream accepts
- `out_lane` output clog2(col) — lane being drained
- `busy` output 1 — high in LOAD or DRAIN
- `done` output 1 — one-cycle pulse at end of pass

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Counters: `cnt` (0..pr-1) and `lane` (0..col-1), shared by LOAD and DRAIN.
- IDLE: `start`=1 → LOAD. Entering LOAD clears `cnt` and `lane` to 0.
- LOAD:
  - `in_ready`=1.
  - Accept = `in_valid & in_ready`.
  - On accept, `norm_wr[lane]`=1 that cycle only, and `cnt` advances.
  - At `cnt==pr-1`, `cnt` wraps to 0 and `lane` advances.
  - On the accept with `lane==col-1` and `cnt==pr-1`: `lane` and `cnt` wrap to 0 and the state goes to DRAIN.
  - `in_ready`=0 in every other state.
- DRAIN:
  - `out_valid = norm_ready[lane]`.
  - Pop = `out_valid & out_ready`.
  - On pop, `norm_div[lane]`=1 that cycle only, and `cnt`/`lane` advance with the same wrap rules as LOAD.
  - The last pop (`lane==col-1`, `cnt==pr-1`) → DONE.
  - With `norm_ready[lane]`=0 the sequencer stalls; no strobe is issued.
- DONE: `done`=1 for exactly one cycle, then unconditional → IDLE.
- `start` outside IDLE is ignored.
- `clear`=1 in any state → IDLE next cycle.
  - Counters zeroed; no strobes issued in the `clear` cycle.
  - Lane contents are not flushed. Lanes are reset only by `reset`.
- `norm_wr` and `norm_div` are never both nonzero. Each is at most one-hot.
- `out_lane` = `lane` in DRAIN, 0 otherwise. `norm_in` = `in_data` always.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE; `cnt`=0, `lane`=0.
  - Outputs `in_ready`=0, `norm_wr`=0, `norm_div`=0, `out_valid`=0, `busy`=0, `done`=0, `out_lane`=0.
  - Holds while `reset`=0. First transition on the first rising edge after release.
- `start` at edge N → LOAD from N+1; `in_ready`=1 and `busy`=1 in cycle N+1.
- `norm_wr` and `norm_div` are combinational from the handshake in the same cycle (zero latency). Counters update at the following edge.
- A full pass with no stalls takes `col*pr` LOAD cycles, then `col*pr` DRAIN cycles, then 1 DONE cycle. `start`→`done` = 2·col·pr+1 cycles after entering LOAD.
- `in_valid` low in LOAD: no accept, counters hold.
- `out_ready` low in DRAIN: no pop; `out_valid` may stay high, and `out_lane` is stable.
- Lane boundary: the accept at `cnt==pr-1` moves `lane` at the next edge. The next accept strobes the new lane with no bubble.
- `reset` asserted mid-pass: immediate return to reset values, with no completion pulse.
- `clear` and the final handshake in the same cycle: `clear` wins; no strobe, no `done`.

## Test plan
- Reset then idle:
  - Stimulus: hold `reset`=0 for 3 cycles, release, no `start`.
  - Required: all outputs 0 and `in_ready`=0 for 10 cycles.
- Full pass, col=8, pr=8, no stalls:
  - Stimulus: `start`, feed `in_data`=0..63, `norm_ready`=8'hFF, `out_ready`=1.
  - Required: `norm_wr` = 8'h01 for accepts 0–7 … 8'h80 for accepts 56–63; 64 `norm_div` pulses in the same lane order; `out_lane` 0..7, each held 8 cycles; `done` exactly 129 cycles after entering LOAD.
- Backpressure:
  - Stimulus: toggle `in_valid` every other cycle, and drive `out_ready`=0 for 5 cycles at DRAIN entry.
  - Required: counters hold during stalls; totals remain 64 writes and 64 reads; no double strobe.
- Lane not ready:
  - Stimulus: `norm_ready`=8'hFE at DRAIN entry, set to 8'hFF after 7 cycles.
  - Required: `out_valid`=0 and no `norm_div` for those 7 cycles; draining of lane 0 starts on the cycle `norm_ready[0]` rises.
- Abort and re-run:
  - Stimulus: `clear` at accept 20, then `start` again.
  - Required: IDLE next cycle, no `done`; the second pass restarts at lane 0, `cnt` 0.
- Asynchronous reset mid-DRAIN:
  - Stimulus: assert `reset`=0 between clock edges at pop 30.
  - Required: outputs go to reset values before the next edge; no `done` pulse.

Source files
------------

// File: rtl/norm_seq.sv
// Load/drain sequencer for the per-column norm lanes.
// It feeds pr psums into each lane, then drains the results lane by lane.
module norm_seq #(
  parameter int col = 8,
  parameter int pr = 8,
  parameter int psum_bw = 12,
  localparam int LW = (col > 1) ? $clog2(col) : 1,
  localparam int CW = (pr > 1) ? $clog2(pr) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [psum_bw-1:0] in_data,
  output logic               in_ready,
  output logic [psum_bw-1:0] norm_in,
  output logic [col-1:0]     norm_wr,
  output logic [col-1:0]     norm_div,
  input  logic [col-1:0]     norm_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LW-1:0]      out_lane,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic [LW-1:0]   lane_q;
  logic [LW-1:0]   lane_d;
  logic            accept;
  logic            pop;
  logic            cnt_end;
  logic            last;
  logic [col-1:0]  lane_oh;

  assign cnt_end = (cnt_q == CW'(pr - 1));
  assign last    = cnt_end && (lane_q == LW'(col - 1));
  assign lane_oh = {{(col-1){1'b0}}, 1'b1} << lane_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      lane_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d  = '0;
          lane_d = '0;
          if (start) state_d = LOAD;
        end
        LOAD:  if (accept && last) state_d = DRAIN;
        DRAIN: if (pop && last) state_d = DONE;
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
      // LOAD and DRAIN walk the same cnt/lane order
      if (accept || pop) begin
        if (cnt_end) begin
          cnt_d  = '0;
          lane_d = last ? '0 : lane_q + LW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN) && norm_ready[lane_q];
    accept    = in_ready && in_valid && !clear;
    pop       = out_valid && out_ready && !clear;
    norm_in   = in_data;
    norm_wr   = accept ? lane_oh : '0;
    norm_div  = pop ? lane_oh : '0;
    out_lane  = (state_q == DRAIN) ? lane_q : '0;
    busy      = (state_q == LOAD) || (state_q == DRAIN);
    done      = (state_q == DONE);
  end

endmodule

// File: tb/tb_norm_seq.sv
// Bench for norm_seq: directed passes plus random handshakes,
// checked every cycle against a flat psum-index model.
module tb_norm_seq;

  localparam int COL = 8;
  localparam int PR  = 8;
  localparam int BW  = 12;
  localparam int TOT = COL * PR;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          clear;
  logic          in_valid;
  logic [BW-1:0] in_data;
  logic          in_ready;
  logic [BW-1:0] norm_in;
  logic [7:0]    norm_wr;
  logic [7:0]    norm_div;
  logic [7:0]    norm_ready;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_lane;
  logic          busy;
  logic          done;

  norm_seq #(.col(COL), .pr(PR), .psum_bw(BW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .norm_in(norm_in),
    .norm_wr(norm_wr),
    .norm_div(norm_div),
    .norm_ready(norm_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane(out_lane),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: phase 0 idle, 1 load, 2 drain, 3 done; k = psums handled so far
  int ph = 0;
  int k  = 0;
  bit m_acc;
  bit m_pop;
  int n_wr;
  int n_div;
  int tl;
  int t_done;
  int dt;
  bit arm_rst;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int lane;
    logic [7:0] oh;
    lane  = k / PR;
    oh    = 8'(1 << lane);
    m_acc = (ph == 1) && in_valid && !clear;
    m_pop = (ph == 2) && norm_ready[lane] && out_ready && !clear;
    chk("in_ready", in_ready, ph == 1);
    chk("norm_wr", norm_wr, m_acc ? oh : 8'h00);
    chk("norm_div", norm_div, m_pop ? oh : 8'h00);
    chk("out_valid", out_valid, (ph == 2) && norm_ready[lane]);
    chk("out_lane", out_lane, (ph == 2) ? lane : 0);
    chk("busy", busy, (ph == 1) || (ph == 2));
    chk("done", done, ph == 3);
    chk("norm_in", norm_in, in_data);
  endtask

  task automatic model_update();
    if (clear) begin
      ph = 0;
      k  = 0;
    end else begin
      case (ph)
        0: if (start) begin ph = 1; k = 0; end
        1: if (m_acc) begin
             k++;
             if (k == TOT) begin ph = 2; k = 0; end
           end
        2: if (m_pop) begin
             k++;
             if (k == TOT) begin ph = 3; k = 0; end
           end
        default: ph = 0;
      endcase
    end
  endtask

  task automatic cyc();
    int kb;
    @(negedge clk);
    if (ph != 0) tl++;
    check_outputs();
    if (norm_wr != 0) n_wr++;
    if (norm_div != 0) n_div++;
    if (done) t_done = tl;
    kb = k;
    if (ph == 2) dt++;
    model_update();
    if (arm_rst && m_pop && kb == 30) begin
      #1 reset = 1'b0;
      #1;
      ph = 0;
      k  = 0;
      check_outputs();
      @(posedge clk);
      #1 reset = 1'b1;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0 clean, 1 backpressure, 2 lane stall, 3 clear at 20,
  // 4 reset at pop 30, 5 random
  task automatic run_pass(input int mode);
    n_wr = 0; n_div = 0; tl = 0; t_done = 0; dt = 0;
    arm_rst = (mode == 4);
    start = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_data = BW'($urandom);
    norm_ready = 8'hFF; out_ready = 1'b1;
    cyc();
    for (int t = 0; t < 800 && ph != 0; t++) begin
      start      = 1'b0;
      clear      = 1'b0;
      in_valid   = 1'b1;
      in_data    = (mode == 0) ? BW'(k) : BW'($urandom);
      norm_ready = 8'hFF;
      out_ready  = 1'b1;
      case (mode)
        1: begin
          in_valid  = t[0];
          out_ready = !(ph == 2 && dt < 5);
        end
        2: norm_ready = (ph == 2 && dt < 7) ? 8'hFE : 8'hFF;
        3: clear = (ph == 1 && k == 20);
        5: begin
          start      = 1'($urandom);
          in_valid   = 1'($urandom);
          out_ready  = 1'($urandom);
          norm_ready = 8'($urandom) | 8'h11;
        end
        default: ;
      endcase
      cyc();
    end
    chk("pass_timeout", ph, 0);
    start = 1'b0; clear = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = '0; norm_ready = 8'hFF; out_ready = 1'b1;
    arm_rst = 1'b0;
    #1 check_outputs();
    repeat (3) @(posedge clk);
    #1 check_outputs();
    reset = 1'b1;
    repeat (10) cyc();

    run_pass(0);
    chk("wr_total_clean", n_wr, TOT);
    chk("rd_total_clean", n_div, TOT);
    chk("done_latency", t_done, 2 * TOT + 1);

    run_pass(1);
    chk("wr_total_bp", n_wr, TOT);
    chk("rd_total_bp", n_div, TOT);

    run_pass(2);
    chk("rd_total_stall", n_div, TOT);

    run_pass(3);
    chk("abort_no_done", t_done, 0);
    repeat (2) cyc();
    run_pass(0);
    chk("wr_total_rerun", n_wr, TOT);
    chk("rd_total_rerun", n_div, TOT);

    repeat (3) begin
      run_pass(5);
      chk("wr_total_rand", n_wr, TOT);
      chk("rd_total_rand", n_div, TOT);
    end

    run_pass(4);
    chk("rst_no_done", t_done, 0);
    chk("rst_pops", n_div, 31);
    repeat (5) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
